// File: rtl/line_echo_pkg.sv
// Shared FSM encoding, echo modes and control characters for the line echo block.
// Pure definitions; no logic, no latency.
package line_echo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DISPATCH,
    ST_EMIT,
    ST_SEND_CR,
    ST_SEND_LF
  } state_t;

  typedef enum logic [1:0] {
    MODE_CHAR = 2'd0,
    MODE_LINE = 2'd1,
    MODE_REV  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Reserved mode falls back to character echo.
  function automatic logic is_line_mode(input mode_t m);
    return (m == MODE_LINE) || (m == MODE_REV);
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Line storage: one write port, one read port with registered read data (1 cycle).
// No backpressure; read data holds while i_rd_en is low.
module line_buf_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              pll_clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_dat,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_dat
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_dat;

  always_ff @(posedge pll_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
    if (i_rd_en) r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/line_echo.sv
// UART echo engine: per-char echo (rx_read->tx_start 3 cycles) or buffered line echo, forward/reversed, plus CR LF.
// tx_full stalls the single output register; nothing is read from RX while a line is being emitted.
module line_echo
  import line_echo_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                LINE_DEPTH = 64,
  parameter logic [DATA_W-1:0] TERM_CHAR  = DATA_W'(8'h0D)
) (
  input  logic              pll_clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              rx_ready,
  output logic              rx_read,
  input  logic [DATA_W-1:0] rx_byte,
  input  logic              tx_full,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              overflow,
  output logic [15:0]       line_count
);

  localparam int              AW       = $clog2(LINE_DEPTH);
  localparam int              FW       = AW + 1;
  localparam logic [FW-1:0]   FILL_MAX = FW'(LINE_DEPTH);

  state_t            r_state;
  mode_t             r_mode_q;
  logic [DATA_W-1:0] r_byte_q;
  logic [FW-1:0]     r_fill;
  logic [FW-1:0]     r_rd_cnt;
  logic              r_rd_vld;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_dat;
  logic              r_rx_read;
  logic              r_overflow;
  logic [15:0]       r_line_count;

  logic              w_push;
  logic              w_out_free;
  logic              w_line;
  logic              w_is_bs;
  logic              w_is_term;
  logic              w_wr_en;
  logic              w_move;
  logic              w_rd_en;
  logic [AW-1:0]     w_rd_idx;
  logic [DATA_W-1:0] w_rd_dat;

  // The output register only leaves when the TX FIFO has room this very cycle.
  assign w_push     = r_out_vld && !tx_full;
  assign w_out_free = !r_out_vld || w_push;
  assign w_line     = is_line_mode(r_mode_q);
  assign w_is_bs    = (r_byte_q == DATA_W'(CHAR_BS));
  assign w_is_term  = (r_byte_q == TERM_CHAR);
  assign w_wr_en    = (r_state == ST_DISPATCH) && w_line && !w_is_bs && !w_is_term
                      && (r_fill != FILL_MAX);
  // RAM output acts as a one-deep prefetch stage in front of the output register.
  assign w_move     = (r_state == ST_EMIT) && r_rd_vld && w_out_free;
  assign w_rd_en    = (r_state == ST_EMIT) && (r_rd_cnt != r_fill) && (!r_rd_vld || w_move);
  assign w_rd_idx   = AW'((r_mode_q == MODE_REV) ? (r_fill - FW'(1) - r_rd_cnt) : r_rd_cnt);

  line_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (LINE_DEPTH),
    .AW     (AW)
  ) u_line_buf_ram (
    .pll_clk   (pll_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_fill[AW-1:0]),
    .i_wr_dat  (r_byte_q),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_idx),
    .o_rd_dat  (w_rd_dat)
  );

  always_ff @(posedge pll_clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode_q     <= MODE_CHAR;
      r_byte_q     <= '0;
      r_fill       <= '0;
      r_rd_cnt     <= '0;
      r_rd_vld     <= 1'b0;
      r_out_vld    <= 1'b0;
      r_out_dat    <= '0;
      r_rx_read    <= 1'b0;
      r_overflow   <= 1'b0;
      r_line_count <= '0;
    end else begin
      r_rx_read <= 1'b0;
      if (w_push) r_out_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_fill == '0) r_mode_q <= mode_t'(mode);
          if (rx_ready) begin
            r_rx_read <= 1'b1;
            r_state   <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_byte_q <= rx_byte;
          r_state  <= ST_DISPATCH;
        end
        ST_DISPATCH: begin
          if (!w_line) begin
            if (w_out_free) begin
              r_out_vld <= 1'b1;
              r_out_dat <= r_byte_q;
              r_state   <= ST_IDLE;
            end
          end else if (w_is_bs) begin
            if (r_fill != '0) r_fill <= r_fill - FW'(1);
            r_state <= ST_IDLE;
          end else if (w_is_term) begin
            r_rd_cnt <= '0;
            r_rd_vld <= 1'b0;
            r_state  <= ST_EMIT;
          end else begin
            if (r_fill == FILL_MAX) r_overflow <= 1'b1;
            else                    r_fill     <= r_fill + FW'(1);
            r_state <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (w_move) begin
            r_out_vld <= 1'b1;
            r_out_dat <= w_rd_dat;
          end
          if (w_rd_en) begin
            r_rd_cnt <= r_rd_cnt + FW'(1);
            r_rd_vld <= 1'b1;
          end else if (w_move) begin
            r_rd_vld <= 1'b0;
          end
          if ((r_rd_cnt == r_fill) && (!r_rd_vld || w_move)) r_state <= ST_SEND_CR;
        end
        ST_SEND_CR: begin
          if (w_out_free) begin
            r_out_vld <= 1'b1;
            r_out_dat <= DATA_W'(CHAR_CR);
            r_state   <= ST_SEND_LF;
          end
        end
        ST_SEND_LF: begin
          if (w_out_free) begin
            r_out_vld    <= 1'b1;
            r_out_dat    <= DATA_W'(CHAR_LF);
            r_fill       <= '0;
            r_line_count <= r_line_count + 16'd1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_read    = r_rx_read;
  assign tx_start   = w_push;
  assign tx_data    = r_out_dat;
  assign overflow   = r_overflow;
  assign line_count = r_line_count;

endmodule

// File: tb/tb_line_echo.sv
// Directed bench for line_echo (LINE_DEPTH=4): RX FIFO model, TX scoreboard queue, immediate-assert checks.
module tb_line_echo;

  logic        pll_clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        rx_ready;
  logic        rx_read;
  logic [7:0]  rx_byte;
  logic        tx_full;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        overflow;
  logic [15:0] line_count;

  always #5 pll_clk = ~pll_clk;

  line_echo #(
    .DATA_W     (8),
    .LINE_DEPTH (4),
    .TERM_CHAR  (8'h0D)
  ) dut (
    .pll_clk    (pll_clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .rx_ready   (rx_ready),
    .rx_read    (rx_read),
    .rx_byte    (rx_byte),
    .tx_full    (tx_full),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .overflow   (overflow),
    .line_count (line_count)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_tx    = 0;
  int         last_rd = -1;
  int         last_tx = -1;
  int         exp_lines = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs and serve the RX FIFO at negedge, return just after posedge.
  task automatic tick();
    logic [7:0] e;
    @(negedge pll_clk);
    cyc++;
    if (tx_start) begin
      n_tx++;
      last_tx = cyc;
      check("tx_start_while_full", 32'(tx_full), 32'd0);
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e));
      end
    end
    if (rx_read) begin
      last_rd = cyc;
      if (rx_q.size() != 0) rx_byte = rx_q.pop_front();
    end
    rx_ready = (rx_q.size() != 0);
    @(posedge pll_clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
  endtask

  task automatic expect_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_lines++;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size() + rx_q.size()), 32'd0);
    repeat (8) tick();
  endtask

  initial begin
    int base;
    int n;
    rst_n    = 1'b0;
    mode     = 2'd0;
    rx_ready = 1'b0;
    rx_byte  = 8'h00;
    tx_full  = 1'b0;
    repeat (3) tick();
    check("rst_rx_read", 32'(rx_read), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_line_count", 32'(line_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Character echo and its latency.
    mode = 2'd0;
    rx_q.push_back(8'h41);
    exp_q.push_back(8'h41);
    drain("char_A");
    check("char_latency", 32'(last_tx - last_rd), 32'd3);

    mode = 2'd3;
    rx_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    drain("mode3");

    // Forward line echo.
    mode = 2'd1;
    send_str("abc");
    rx_q.push_back(8'h0D);
    expect_line("abc");
    drain("line_abc");
    check("line_count_1", 32'(line_count), 32'(exp_lines));

    // Reversed line with backspace.
    mode = 2'd2;
    send_str("abc");
    rx_q.push_back(8'h08);
    send_str("d");
    rx_q.push_back(8'h0D);
    expect_line("dba");
    drain("rev_bs");
    check("line_count_2", 32'(line_count), 32'(exp_lines));

    // Overflow of the 4-entry buffer.
    mode = 2'd1;
    send_str("abcdef");
    rx_q.push_back(8'h0D);
    expect_line("abcd");
    drain("overflow_line");
    check("overflow_set", 32'(overflow), 32'd1);
    send_str("hi");
    rx_q.push_back(8'h0D);
    expect_line("hi");
    drain("after_overflow");
    check("overflow_sticky", 32'(overflow), 32'd1);
    check("line_count_4", 32'(line_count), 32'(exp_lines));

    // TX stall in the middle of a line.
    send_str("wxyz");
    rx_q.push_back(8'h0D);
    expect_line("wxyz");
    base = n_tx;
    n = 0;
    while (n_tx < base + 2 && n < 200) begin
      tick();
      n++;
    end
    check("stall_reached", 32'(n_tx - base), 32'd2);
    tx_full = 1'b1;
    base = n_tx;
    repeat (10) tick();
    check("stall_no_tx", 32'(n_tx - base), 32'd0);
    tx_full = 1'b0;
    drain("stall_line");
    check("line_count_5", 32'(line_count), 32'(exp_lines));

    // Mode change is deferred until the buffer empties.
    mode = 2'd1;
    send_str("pq");
    drain("partial");
    mode = 2'd0;
    send_str("r");
    rx_q.push_back(8'h0D);
    expect_line("pqr");
    drain("mode_defer");
    rx_q.push_back(8'h6B);
    exp_q.push_back(8'h6B);
    drain("mode_applied");
    check("line_count_6", 32'(line_count), 32'(exp_lines));

    // Reset while a line is stuck in EMIT.
    mode    = 2'd1;
    tx_full = 1'b1;
    send_str("abcd");
    rx_q.push_back(8'h0D);
    repeat (40) tick();
    rst_n = 1'b0;
    tick();
    tx_full = 1'b0;
    #1;
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_rx_read", 32'(rx_read), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_line_count", 32'(line_count), 32'd0);
    rst_n     = 1'b1;
    exp_lines = 0;
    tick();

    send_str("xy");
    rx_q.push_back(8'h0D);
    expect_line("xy");
    drain("post_reset");
    check("post_reset_count", 32'(line_count), 32'(exp_lines));
    check("post_reset_overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_echo.md
LINE_ECHO -- requirements
Module: line_echo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width in bits.
REQ-002 SHALL have parameter LINE_DEPTH, default 64, line buffer entries; power of two, 4..256.
REQ-003 SHALL have parameter TERM_CHAR, default 8'h0D, line terminator.
REQ-004 SHALL have port pll_clk  in  1  clock.
REQ-005 SHALL have port rst_n  in  1  reset; synchronous, active-low; clock pll_clk.
REQ-006 SHALL have port mode  in  2  0=char echo, 1=line echo, 2=reversed line echo, 3=reserved (treated as 0).
REQ-007 SHALL have port rx_ready  in  1  UART RX FIFO non-empty.
REQ-008 SHALL have port rx_read  out  1  one-cycle pop request to the UART RX FIFO.
REQ-009 SHALL have port rx_byte  in  DATA_W  RX FIFO head; valid in the cycle after rx_read is high.
REQ-010 SHALL have port tx_full  in  1  UART TX FIFO full.
REQ-011 SHALL have port tx_start  out  1  one-cycle push to the UART TX FIFO.
REQ-012 SHALL have port tx_data  out  DATA_W  byte pushed; valid while tx_start is high.
REQ-013 SHALL have port overflow  out  1  sticky; a byte was dropped on a full line buffer.
REQ-014 SHALL have port line_count  out  16  lines emitted since reset; wraps 0xFFFF->0.

Function
REQ-015 SHALL run the FSM states IDLE, RD_REQ, RD_WAIT, DISPATCH, EMIT, SEND_CR, SEND_LF.
REQ-016 IDLE: SHALL latch mode into mode_q only when the line buffer is empty, and SHALL go to RD_REQ when rx_ready=1.
REQ-017 RD_REQ: SHALL drive rx_read=1 for exactly one cycle, then go to RD_WAIT.
REQ-018 RD_WAIT: SHALL capture rx_byte into byte_q, then go to DISPATCH.
REQ-019 DISPATCH, mode_q=0: SHALL push byte_q to TX (one tx_start pulse, tx_data=byte_q) once tx_full=0, then go to IDLE; minimum rx_read-to-tx_start latency is 3 cycles.
REQ-020 DISPATCH, mode_q 1/2, byte_q=8'h08 (backspace): SHALL decrement the fill level if non-zero, then go to IDLE; nothing emitted.
REQ-021 DISPATCH, mode_q 1/2, byte_q=TERM_CHAR: SHALL go to EMIT; the terminator is not stored.
REQ-022 DISPATCH, mode_q 1/2, other byte: SHALL store it at the fill index if fill<LINE_DEPTH; otherwise SHALL drop it and set overflow. Then go to IDLE.
REQ-023 EMIT: SHALL push one stored byte per cycle while tx_full=0, with tx_start low while tx_full=1 and no byte lost; mode_q=1 in store order, mode_q=2 in reverse order; after the last byte go to SEND_CR.
REQ-024 EMIT with an empty buffer SHALL go straight to SEND_CR.
REQ-025 SEND_CR then SEND_LF SHALL each push 8'h0D then 8'h0A under the same tx_full rule; on leaving SEND_LF SHALL clear the fill level, increment line_count, and go to IDLE.
REQ-026 SHALL never assert rx_read during EMIT, SEND_CR or SEND_LF; RX bytes stay in the UART FIFO.
REQ-027 SHALL never assert tx_start when tx_full=1 in the same cycle.
REQ-028 Fill counter SHALL be clog2(LINE_DEPTH)+1 bits so a full buffer is distinct from an empty one.
REQ-029 A mode change while the buffer is non-empty SHALL take effect only after the buffer empties.

Reset
REQ-030 On rst_n=0 at a pll_clk edge: state=IDLE, rx_read=0, tx_start=0, tx_data=0, overflow=0, line_count=0, fill=0, mode_q=0.
REQ-031 Reset asserted mid-EMIT SHALL abort the line with no further tx_start; line buffer contents are don't-care.

Structure
REQ-032 FSM state encoding, the 8'h08/8'h0D/8'h0A constants and the mode encodings SHALL live in the shared package line_echo_pkg.
REQ-033 Line storage SHALL be the sub-module line_buf_ram (1 write port, 1 read port with registered read, depth LINE_DEPTH, width DATA_W); EMIT accounts for its 1-cycle read latency.

Verification
REQ-034 mode=0, RX "A" (8'h41) -> exactly one tx_start with tx_data=8'h41, 3 cycles after rx_read.
REQ-035 mode=1, RX "abc",8'h0D -> TX 61,62,63,0D,0A; line_count=1.
REQ-036 mode=2, RX "abc",8'h08,"d",8'h0D -> TX 64,62,61,0D,0A.
REQ-037 mode=1, LINE_DEPTH=4, RX "abcdef",8'h0D -> TX 61..64,0D,0A; overflow=1 and stays 1.
REQ-038 mode=1, tx_full held high 10 cycles mid-EMIT -> no tx_start during the stall, no byte lost or duplicated.
REQ-039 rst_n low for 1 cycle during EMIT -> all outputs at reset values next cycle; the next line echoes correctly.
